// File: rtl/uart_tx_buffer_if.sv
// Push port and transmitter launch/status signals of the UART TX byte buffer.
interface uart_tx_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data_in;
  logic              tx_busy;
  logic              tx_timeout;

  // master = host plus transmitter side, slave = the buffer itself
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, overflow, tx_start, tx_data_in, tx_timeout
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, overflow, tx_start, tx_data_in, tx_timeout
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO that feeds the UART transmitter one frame at a time, pacing on tx_busy
// and abandoning a frame if the transmitter never acknowledges the launch.
module uart_tx_buffer #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 8,
  parameter int BUSY_TO = 32
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(BUSY_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start, tx_timeout, timeout_nxt, overflow;
  logic              full, empty, push, pop;

  // full/empty come from the registered count, so wr_en never reaches full combinationally
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.wr_en && !full;
  assign pop   = (state == IDLE) && !empty;

  // NOTE: the storage array has no reset; stale bytes are unreachable because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow <= bus.wr_en && full;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        state_nxt  = WAIT_BUSY;
        to_cnt_nxt = '0;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      tx_start   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      to_cnt     <= to_cnt_nxt;
      tx_start   <= (state_nxt == LAUNCH);
      tx_timeout <= timeout_nxt;
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count;
  assign bus.overflow   = overflow;
  assign bus.tx_start   = tx_start;
  assign bus.tx_data_in = tx_data;
  assign bus.tx_timeout = tx_timeout;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: push tables, a transmitter model answering
// tx_start with tx_busy, and hand-written timeout/reset/wrap sequences.
module tb_uart_tx_buffer;
  localparam int DEPTH   = 16;
  localparam int DATA_W  = 8;
  localparam int BUSY_TO = 32;
  localparam int NV      = 21;

  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  uart_tx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BUSY_TO(BUSY_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] start_q[$];
  int         start_double = 0;
  logic       prev_start = 1'b0;
  bit         model_en = 1'b1;
  bit         model_active = 1'b0;
  bit         frame_aborted = 1'b0;
  int         busy_dly = 2;
  int         busy_len = 100;
  int         peak_count;
  bit         full_seen;
  vec_t       vecs[NV];
  int         t, to_edge, to_pulses, restart_edge, n0, idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (int'(bus.count) > peak_count) peak_count = int'(bus.count);
    if (bus.full) full_seen = 1'b1;
  endtask

  // Wait for n launches with the model idle and the FIFO empty, then let the FSM settle.
  task automatic drain(input int n, input int limit);
    int c = 0;
    do begin
      step();
      c++;
    end while ((start_q.size() < n || model_active || !bus.empty) && c < limit);
    check("drain_in_time", (c < limit), 1);
    repeat (3) step();
  endtask

  function automatic logic [7:0] wrap_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Launch monitor: logs every launched byte and flags a tx_start wider than one cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_start) begin
        start_q.push_back(bus.tx_data_in);
        if (prev_start) start_double++;
      end
      prev_start = bus.tx_start;
    end
  end

  // Transmitter model: tx_busy rises busy_dly cycles after tx_start and stays up busy_len cycles.
  initial begin
    logic [7:0] cap;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && bus.tx_start) begin
        model_active = 1'b1;
        cap = bus.tx_data_in;
        @(posedge clk);
        #1;
        check("start_one_cycle", bus.tx_start, 0);
        repeat (busy_dly - 1) begin @(posedge clk); #1; end
        bus.tx_busy = 1'b1;
        repeat (busy_len) begin @(posedge clk); #1; end
        if (!frame_aborted) check("data_held_through_frame", bus.tx_data_in, cap);
        bus.tx_busy = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 18; i++) begin
      vecs[i].wr_en     = 1'b1;
      vecs[i].wr_data   = 8'(8'h40 + i);
      vecs[i].exp_count = (i == 0) ? 5'd1 : ((i > 16) ? 5'd16 : 5'(i));
      vecs[i].exp_full  = (i >= 16);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_ovf   = (i == 17);
    end
    vecs[18] = '{wr_en:1'b0, wr_data:8'h00, exp_count:5'd16, exp_full:1'b1, exp_empty:1'b0, exp_ovf:1'b0};
    vecs[19] = '{wr_en:1'b1, wr_data:8'h99, exp_count:5'd16, exp_full:1'b1, exp_empty:1'b0, exp_ovf:1'b1};
    vecs[20] = '{wr_en:1'b0, wr_data:8'h00, exp_count:5'd16, exp_full:1'b1, exp_empty:1'b0, exp_ovf:1'b0};

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.tx_busy = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data_in", bus.tx_data_in, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_tx_timeout", bus.tx_timeout, 0);
    rst = 1'b0;
    step();

    // Single byte: launch one cycle after the push edge.
    start_q.delete();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    check("single_count_after_push", bus.count, 1);
    check("single_empty_after_push", bus.empty, 0);
    check("single_no_start_yet", bus.tx_start, 0);
    step();
    check("single_start", bus.tx_start, 1);
    check("single_data", bus.tx_data_in, 8'hA5);
    check("single_count_after_pop", bus.count, 0);
    drain(1, 400);
    check("single_frames", start_q.size(), 1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h5A;
    step();
    bus.wr_en = 1'b0;
    step();
    check("single_relaunch_from_idle", bus.tx_start, 1);
    check("single_relaunch_data", bus.tx_data_in, 8'h5A);
    drain(2, 400);

    // Burst of 16: first byte pops at once, so the FIFO peaks at 15.
    busy_len = 20;
    start_q.delete();
    peak_count = 0;
    full_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
    drain(16, 2000);
    check("burst_peak_count", peak_count, 15);
    check("burst_full_never", full_seen, 0);
    check("burst_frames", start_q.size(), 16);
    for (int i = 0; i < 16 && i < start_q.size(); i++) check("burst_order", start_q[i], 8'(i));

    // Overflow table with the transmitter held busy.
    model_en = 1'b0;
    bus.tx_busy = 1'b1;
    start_q.delete();
    for (int i = 0; i < NV; i++) begin
      bus.wr_en = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      step();
      check("ovf_count", bus.count, vecs[i].exp_count);
      check("ovf_full", bus.full, vecs[i].exp_full);
      check("ovf_empty", bus.empty, vecs[i].exp_empty);
      check("ovf_pulse", bus.overflow, vecs[i].exp_ovf);
    end
    bus.wr_en = 1'b0;
    busy_len = 5;
    bus.tx_busy = 1'b0;
    model_en = 1'b1;
    drain(17, 2000);
    check("ovf_frames", start_q.size(), 17);
    for (int i = 0; i < 17 && i < start_q.size(); i++) check("ovf_order", start_q[i], 8'(8'h40 + i));

    // Timeout: tx_busy never rises; the queued second byte relaunches after the pulse.
    model_en = 1'b0;
    bus.tx_busy = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C;
    step();
    bus.wr_data = 8'h77;
    step();
    bus.wr_en = 1'b0;
    check("to_start", bus.tx_start, 1);
    check("to_data", bus.tx_data_in, 8'h3C);
    t = 0;
    to_edge = -1;
    to_pulses = 0;
    restart_edge = -1;
    while (restart_edge < 0 && t < BUSY_TO + 20) begin
      step();
      t++;
      if (bus.tx_timeout) begin
        to_pulses++;
        if (to_edge < 0) to_edge = t;
      end
      if (bus.tx_start) restart_edge = t;
    end
    check("to_delay_after_start_fall", to_edge - 1, BUSY_TO);
    check("to_single_pulse", to_pulses, 1);
    check("to_relaunch_edge", restart_edge, to_edge + 1);
    check("to_relaunch_data", bus.tx_data_in, 8'h77);

    // Reset mid-frame with five bytes queued and the FSM waiting for tx_busy to fall.
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_en = 1'b1;
    busy_len = 100;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      step();
    end
    bus.wr_en = 1'b0;
    check("rstmid_pre_count", bus.count, 5);
    check("rstmid_pre_busy", bus.tx_busy, 1);
    frame_aborted = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_count", bus.count, 0);
    check("rstmid_empty", bus.empty, 1);
    check("rstmid_tx_start", bus.tx_start, 0);
    check("rstmid_tx_data_in", bus.tx_data_in, 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = start_q.size();
    repeat (130) step();
    check("rstmid_no_launch", start_q.size(), n0);
    check("rstmid_still_empty", bus.empty, 1);
    frame_aborted = 1'b0;

    // Wrap: 40 bytes, every pop edge after the first also carries a push.
    busy_len = 4;
    start_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = wrap_byte(i);
      step();
    end
    bus.wr_en = 1'b0;
    idle = 5;
    for (int k = 1; k <= 36; k++) begin
      repeat (idle) step();
      check("wrap_count_pre", bus.count, 3);
      bus.wr_en = 1'b1;
      bus.wr_data = wrap_byte(3 + k);
      step();
      bus.wr_en = 1'b0;
      check("wrap_count_post", bus.count, 3);
      check("wrap_pop_edge", bus.tx_start, 1);
      idle = 7;
    end
    drain(40, 3000);
    check("wrap_frames", start_q.size(), 40);
    for (int i = 0; i < 40 && i < start_q.size(); i++) check("wrap_order", start_q[i], wrap_byte(i));
    check("start_pulse_width", start_double, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and launch sequencer that sits directly upstream of the UART transmitter inside `uart_top`. Host logic pushes bytes at clock rate. The block drains them one frame at a time by driving `tx_start`/`tx_data_in` and pacing on the transmitter's `tx_busy` status. This decouples bursty producers from the baud-rate-limited serial line for every `sel` baud setting.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DATA_W`, 8: byte width; must match the transmitter data width.
- `BUSY_TO`, 32: cycles to wait for `tx_busy` to rise after `tx_start` before abandoning the frame.

- `clk`  in  1: system clock, same clock as `uart_top`.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: push request; sampled on the rising edge of `clk`.
- `wr_data`  in  `DATA_W`: byte to push.
- `full`  out  1: FIFO holds `DEPTH` entries.
- `empty`  out  1: FIFO holds 0 entries.
- `count`  out  $clog2(`DEPTH`)+1: current occupancy.
- `overflow`  out  1: one-cycle pulse when `wr_en` arrives while `full`.
- `tx_start`  out  1: one-cycle launch pulse to the transmitter.
- `tx_data_in`  out  `DATA_W`: byte being sent; held stable from `tx_start` until the frame ends.
- `tx_busy`  in  1: transmitter is shifting a frame.
- `tx_timeout`  out  1: one-cycle pulse when `BUSY_TO` expires.

## Operation
- **FIFO:** circular buffer with wrapping read/write pointers. `full` and `empty` are derived from `count`.
  - A push is accepted when `wr_en && !full`.
  - `full` is evaluated before a same-edge pop, so a push while full is always rejected, even when a pop happens on that edge. The rejected byte is dropped and `overflow` pulses.
  - A simultaneous accepted push and pop leaves `count` unchanged.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - **IDLE:** if `!empty`, pop the head into the `tx_data_in` register and go to LAUNCH. Otherwise stay.
  - **LAUNCH:** `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY and clear the timeout counter.
  - **WAIT_BUSY:** if `tx_busy`=1, go to WAIT_DONE. Otherwise increment the timeout counter. When the counter reaches `BUSY_TO`-1, pulse `tx_timeout` and go to IDLE; the byte is lost.
  - **WAIT_DONE:** when `tx_busy`=0, go to IDLE.
- **Output registers:**
  - `tx_start` and `tx_timeout` are registered outputs.
  - `tx_data_in` changes only on a pop edge and otherwise retains its value.
- **Reset:** asynchronous, mid-operation included.
  - State returns to IDLE, pointers and `count` clear, and FIFO contents are discarded.
  - An in-flight frame is not tracked after reset.
- **Reset values:** `tx_start`=0, `tx_data_in`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0, `tx_timeout`=0.

## Timing
- **Push to count:** a push accepted at edge E0 makes `count` and `empty` update after E0.
- **Push to launch:** with the FSM in IDLE, a push accepted at E0 causes a pop at E1, with `tx_data_in` valid after E1. `tx_start` is high between E1 and E2, so the transmitter samples it at E2.
- **Frame to frame:** after `tx_busy` falls (first sampled low at edge Ed), IDLE is entered at Ed. The next pop and `tx_start` happen at Ed+1. The minimum gap from `tx_busy` falling to the next `tx_start` is 1 idle cycle.
- **Busy rise:** `tx_busy` must rise within `BUSY_TO` cycles after `tx_start` falls. Otherwise `tx_timeout` fires on the last counted cycle.
- **Back-pressure:** `full` is registered and reflects the state after the previous edge. There is no combinational path from `wr_en` to `full`.
- **Pointer wrap-around:** at `DEPTH`-1→0 there is no bubble.
- **Throughput:** at most one frame is in flight; a pop never occurs outside IDLE.

## Test plan
- **Single byte:** reset, then push 0xA5 once; the transmitter model raises `tx_busy` 2 cycles after `tx_start`, holds it for 100 cycles. Required: `tx_start` is high exactly 1 cycle, one cycle after the push edge; `tx_data_in`=0xA5 throughout busy; `count` goes 1→0 at the pop; FSM returns to IDLE.
- **Burst fill and drain:** push 0x00..0x0F on consecutive cycles with `DEPTH`=16. Required: `count` peaks at 15 because the first byte pops immediately; `full` never asserts; 16 frames are sent in order with one `tx_start` per frame.
- **Overflow:** hold `tx_busy`=1 and push 18 bytes. Required: `full`=1 after 17 accepted pushes (1 popped, 16 stored); the 18th push pulses `overflow` and is dropped; drained sequence excludes the 18th byte.
- **Timeout:** push 0x3C and never assert `tx_busy`. Required: `tx_timeout` pulses once, `BUSY_TO` cycles after `tx_start`; the FSM relaunches the next queued byte.
- **Reset mid-frame:** with 5 bytes queued and the FSM in WAIT_DONE, assert `rst` asynchronously between edges. Required: `count`=0, `empty`=1, `tx_start`=0, `tx_data_in`=0 immediately; no `tx_start` after `rst` releases until a new push.
- **Wrap and simultaneous push/pop:** stream 40 bytes, with a push on the same edge as each pop. Required: `count` stays constant across those edges; order is preserved across the pointer wrap.
